// File: rtl/ff256_pow_ctrl_if.sv
// Request/response bundle for the GF(2^8) exponentiation controller.
// The requester drives start and the operands; the controller returns the result, busy and done.
interface ff256_pow_ctrl_if;
  logic       start;
  logic [7:0] base_in;
  logic [7:0] exp_in;
  logic [7:0] result_out;
  logic       busy;
  logic       done;

  modport master (
    output start,
    output base_in,
    output exp_in,
    input  result_out,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  base_in,
    input  exp_in,
    output result_out,
    output busy,
    output done
  );
endinterface

// File: rtl/ff256_pow_ctrl.sv
// GF(2^8) exponentiation a^e, field polynomial x^8+x^4+x^3+x+1 (0x11B).
// Left-to-right square-and-multiply over one time-shared multiplier, fixed 16-edge latency.

module ff256_mult_xfx_mult (
  input  logic [7:0] i_a,
  output logic [7:0] o_y
);
  // Multiply by x, folding the overflow term back with the low byte of 0x11B
  assign o_y = {i_a[6:0], 1'b0} ^ (i_a[7] ? 8'h1B : 8'h00);
endmodule

module ff256_mult_multiplier (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_p
);
  logic [7:0] w_x0, w_x1, w_x2, w_x3, w_x4, w_x5, w_x6, w_x7;

  assign w_x0 = i_a;
  ff256_mult_xfx_mult u_xt1 (.i_a(w_x0), .o_y(w_x1));
  ff256_mult_xfx_mult u_xt2 (.i_a(w_x1), .o_y(w_x2));
  ff256_mult_xfx_mult u_xt3 (.i_a(w_x2), .o_y(w_x3));
  ff256_mult_xfx_mult u_xt4 (.i_a(w_x3), .o_y(w_x4));
  ff256_mult_xfx_mult u_xt5 (.i_a(w_x4), .o_y(w_x5));
  ff256_mult_xfx_mult u_xt6 (.i_a(w_x5), .o_y(w_x6));
  ff256_mult_xfx_mult u_xt7 (.i_a(w_x6), .o_y(w_x7));

  // Each set bit of b selects the matching a*x^k partial product
  assign o_p = ({8{i_b[0]}} & w_x0) ^ ({8{i_b[1]}} & w_x1) ^
               ({8{i_b[2]}} & w_x2) ^ ({8{i_b[3]}} & w_x3) ^
               ({8{i_b[4]}} & w_x4) ^ ({8{i_b[5]}} & w_x5) ^
               ({8{i_b[6]}} & w_x6) ^ ({8{i_b[7]}} & w_x7);
endmodule

module ff256_pow_ctrl (
  input  logic               clk,
  input  logic               rst,
  ff256_pow_ctrl_if.slave    bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SQR  = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_acc;
  logic [7:0] r_baseReg;
  logic [7:0] r_expReg;
  logic [2:0] r_bitIdx;
  logic [7:0] r_opA;
  logic [7:0] r_opB;
  logic [7:0] r_result;
  logic       r_busy;
  logic       r_done;
  logic [7:0] w_prod;
  logic [7:0] w_mulAcc;

  ff256_mult_multiplier u_mul (
    .i_a (r_opA),
    .i_b (r_opB),
    .o_p (w_prod)
  );

  // In MUL the product is kept only when the current exponent bit is set
  assign w_mulAcc = r_expReg[r_bitIdx] ? w_prod : r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_nextState = S_SQR;
      S_SQR:   w_nextState = S_MUL;
      S_MUL:   w_nextState = (r_bitIdx == 3'd0) ? S_DONE : S_SQR;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Operand registers are loaded one edge ahead so the multiplier already
  // sees (acc,acc) in SQR and (acc,base) in MUL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= 8'h01;
      r_baseReg <= 8'h00;
      r_expReg  <= 8'h00;
      r_bitIdx  <= 3'd7;
      r_opA     <= 8'h01;
      r_opB     <= 8'h01;
      r_result  <= 8'h00;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_baseReg <= bus.base_in;
            r_expReg  <= bus.exp_in;
            r_acc     <= 8'h01;
            r_bitIdx  <= 3'd7;
            r_opA     <= 8'h01;
            r_opB     <= 8'h01;
            r_busy    <= 1'b1;
          end
        end
        S_SQR: begin
          r_acc <= w_prod;
          r_opA <= w_prod;
          r_opB <= r_baseReg;
        end
        S_MUL: begin
          r_acc <= w_mulAcc;
          r_opA <= w_mulAcc;
          r_opB <= w_mulAcc;
          if (r_bitIdx == 3'd0) begin
            r_result <= w_mulAcc;
            r_done   <= 1'b1;
          end else begin
            r_bitIdx <= r_bitIdx - 3'd1;
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
        default: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result_out = r_result;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

  a_doneWhileBusy: assert property (@(posedge clk) disable iff (rst) r_done |-> r_busy);
  a_donePulse:     assert property (@(posedge clk) disable iff (rst) r_done |=> !r_done);
  a_idleNotBusy:   assert property (@(posedge clk) disable iff (rst) (r_state == S_IDLE) |-> !r_busy);
endmodule
